game_ctrl: RTL and testbench

//  Top-level game supervisor for the runner game. Consumes the obstacle and dino positions,

---
 rtl/game_pkg.sv | 25 ++
 rtl/btn_sync_edge.sv | 31 +++
 rtl/game_ctrl.sv | 100 ++++++++++
 tb/tb_game_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared encodings and screen constants for the runner game.
// Included by the game supervisor and anything that decodes its state.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_OVER = 2'b10
    } game_state_e;

    localparam int OBS_PARK_X = 900;
    localparam int OBS_WRAP_X = 896;
    localparam int GROUND_Y   = 400;

    localparam int unsigned DEF_DINO_W      = 40;
    localparam int unsigned DEF_DINO_H      = 40;
    localparam int unsigned DEF_OBS_W       = 20;
    localparam int unsigned DEF_OBS_H       = 40;
    localparam int unsigned DEF_HOLD_CYCLES = 50_000_000;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser plus rising-edge detect for a raw push button.
// The pulse is registered, so it appears three clocks after the raw edge.
module btn_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw_i,
    output logic pulse_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic pulse_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= btn_raw_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            pulse_q <= sync2_q & ~prev_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/game_ctrl.sv
// Runner game supervisor: collision detection, score keeping and the
// IDLE/RUN/OVER state that the obstacle mover and display path follow.
module game_ctrl
    import game_pkg::*;
#(
    parameter int unsigned DINO_W      = DEF_DINO_W,
    parameter int unsigned DINO_H      = DEF_DINO_H,
    parameter int unsigned OBS_W       = DEF_OBS_W,
    parameter int unsigned OBS_H       = DEF_OBS_H,
    parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_btn_i,
    input  logic [9:0]  dino_x_i,
    input  logic [9:0]  dino_y_i,
    input  logic [9:0]  obs_x_i,
    input  logic [9:0]  obs_y_i,
    output logic [1:0]  state_o,
    output logic [15:0] score_o,
    output logic [15:0] high_score_o,
    output logic        collision_o
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES - 1);

    game_state_e       state_q;
    logic [15:0]       score_q;
    logic [15:0]       high_q;
    logic              coll_q;
    logic [HOLD_W-1:0] hold_q;
    logic [9:0]        obs_x_q;

    logic jump_p;
    logic hit;
    logic wrap;

    btn_sync_edge u_jump_sync (
        .clk       (clk),
        .rst       (rst),
        .btn_raw_i (jump_btn_i),
        .pulse_o   (jump_p)
    );

    // 11-bit compare so edge + size can never wrap around
    logic [10:0] dino_l, dino_t, obs_l, obs_t;
    assign dino_l = {1'b0, dino_x_i};
    assign dino_t = {1'b0, dino_y_i};
    assign obs_l  = {1'b0, obs_x_i};
    assign obs_t  = {1'b0, obs_y_i};

    assign hit = (dino_l < obs_l + 11'(OBS_W))  && (obs_l < dino_l + 11'(DINO_W)) &&
                 (dino_t < obs_t + 11'(OBS_H))  && (obs_t < dino_t + 11'(DINO_H));

    assign wrap = obs_x_i > obs_x_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            score_q <= '0;
            high_q  <= '0;
            coll_q  <= 1'b0;
            hold_q  <= '0;
            obs_x_q <= '0;
        end else begin
            coll_q  <= hit;
            obs_x_q <= obs_x_i;
            unique case (state_q)
                ST_IDLE: begin
                    if (jump_p) begin
                        state_q <= ST_RUN;
                        score_q <= '0;
                    end
                end
                ST_RUN: begin
                    // a hit wins over a same-edge wrap: the obstacle was not cleared
                    if (hit) begin
                        state_q <= ST_OVER;
                        hold_q  <= '0;
                        if (score_q > high_q) high_q <= score_q;
                    end else if (wrap) begin
                        score_q <= sat_inc16(score_q);
                    end
                end
                ST_OVER: begin
                    if (hold_q != HOLD_MAX) hold_q <= hold_q + HOLD_W'(1);
                    if (jump_p && hold_q == HOLD_MAX) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign state_o      = state_q;
    assign score_o      = score_q;
    assign high_score_o = high_q;
    assign collision_o  = coll_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: directed scenarios plus random play, all checked
// against a cycle-stepped behavioural model of the game rules.
module tb_game_ctrl;

    localparam int HOLD = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        jump = 1'b0;
    logic [9:0]  dx = 10'd100, dy = 10'd400, ox = 10'd500, oy = 10'd400;
    logic [1:0]  state;
    logic [15:0] score, high;
    logic        coll;

    int n_pass = 0;
    int n_total = 0;

    // reference model
    int       m_state = 0;
    int       m_score = 0;
    int       m_high = 0;
    int       m_hold = 0;
    int       m_prevx = 0;
    bit       m_coll = 1'b0;
    bit [3:0] m_hist = 4'b0;

    game_ctrl #(.HOLD_CYCLES(HOLD)) dut (
        .clk          (clk),
        .rst          (rst),
        .jump_btn_i   (jump),
        .dino_x_i     (dx),
        .dino_y_i     (dy),
        .obs_x_i      (ox),
        .obs_y_i      (oy),
        .state_o      (state),
        .score_o      (score),
        .high_score_o (high),
        .collision_o  (coll)
    );

    always #5 clk = ~clk;

    // One clock edge; the model consumes the inputs as they stood before it.
    task automatic tick();
        int  ns, nsc, nh, nhold;
        bit  hit, wrap, jp;
        ns = m_state; nsc = m_score; nh = m_high; nhold = m_hold;
        hit  = (int'(dx) < int'(ox) + 20) && (int'(ox) < int'(dx) + 40) &&
               (int'(dy) < int'(oy) + 40) && (int'(oy) < int'(dy) + 40);
        wrap = int'(ox) > m_prevx;
        jp   = m_hist[2] & ~m_hist[3];
        if (!rst) begin
            if (m_state == 0 && jp) begin
                ns = 1; nsc = 0;
            end else if (m_state == 1) begin
                if (hit) begin
                    ns = 2; nhold = 0;
                    nh = (m_score > m_high) ? m_score : m_high;
                end else if (wrap) begin
                    nsc = (m_score < 65535) ? m_score + 1 : 65535;
                end
            end else if (m_state == 2) begin
                nhold = (m_hold < HOLD - 1) ? m_hold + 1 : HOLD - 1;
                if (jp && m_hold == HOLD - 1) ns = 0;
            end
        end
        @(posedge clk);
        #1;
        if (rst) begin
            m_state = 0; m_score = 0; m_high = 0; m_hold = 0;
            m_prevx = 0; m_coll = 1'b0; m_hist = 4'b0;
        end else begin
            m_state = ns; m_score = nsc; m_high = nh; m_hold = nhold;
            m_prevx = int'(ox); m_coll = hit; m_hist = {m_hist[2:0], jump};
        end
    endtask

    task automatic press_start();
        jump = 1'b1;
        repeat (4) tick();
        jump = 1'b0;
        tick();
    endtask

    task automatic do_wraps(input int n);
        for (int i = 0; i < n; i++) begin
            ox = 10'd2;   tick();
            ox = 10'd896; tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        n_total++;
        if ({state, score, high, coll} !== 35'd0)
            $display("FAIL reset: state=%b score=%h high=%h coll=%b, want all 0", state, score, high, coll);
        else n_pass++;
    endtask

    task automatic test_start();
        dx = 10'd100; dy = 10'd400; ox = 10'd500; oy = 10'd400;
        jump = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            tick();
            n_total++;
            if (state !== ((e == 4) ? 2'b01 : 2'b00))
                $display("FAIL start_edge%0d: state=%b, want %b", e, state, (e == 4) ? 2'b01 : 2'b00);
            else n_pass++;
        end
        repeat (6) tick();
        jump = 1'b0;
        n_total++;
        if (state !== 2'b01 || score !== 16'd0)
            $display("FAIL start_hold: state=%b score=%0d, want 01 and 0", state, score);
        else n_pass++;
    endtask

    task automatic test_score();
        ox = 10'd5;   tick();
        ox = 10'd2;   tick();
        n_total++;
        if (score !== 16'd0) $display("FAIL score_prewrap: score=%0d, want 0", score);
        else n_pass++;
        ox = 10'd896; tick();
        n_total++;
        if (score !== 16'd1) $display("FAIL score_wrap1: score=%0d, want 1", score);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            ox = 10'd5; tick(); ox = 10'd2; tick(); ox = 10'd896; tick();
        end
        n_total++;
        if (score !== 16'd4 || score !== 16'(m_score))
            $display("FAIL score_wrap4: score=%0d, want 4 (model %0d)", score, m_score);
        else n_pass++;
    endtask

    task automatic test_collision();
        dx = 10'd100; dy = 10'd400; ox = 10'd110; oy = 10'd400;
        tick();
        n_total++;
        if (coll !== 1'b1 || state !== 2'b10 || high !== 16'd4)
            $display("FAIL collision: coll=%b state=%b high=%0d, want 1 10 4", coll, state, high);
        else n_pass++;
    endtask

    task automatic test_hold();
        ox = 10'd500; jump = 1'b1;
        tick(); tick();
        jump = 1'b0;
        tick(); tick();
        n_total++;
        if (state !== 2'b10 || coll !== 1'b0)
            $display("FAIL hold_early_jump: state=%b coll=%b, want 10 0", state, coll);
        else n_pass++;
        repeat (10) tick();
        jump = 1'b1;
        repeat (3) tick();
        n_total++;
        if (state !== 2'b10) $display("FAIL hold_latency: state=%b, want 10", state);
        else n_pass++;
        tick();
        jump = 1'b0;
        n_total++;
        if (state !== 2'b00 || score !== 16'd4 || high !== 16'd4)
            $display("FAIL hold_release: state=%b score=%0d high=%0d, want 00 4 4", state, score, high);
        else n_pass++;
    endtask

    task automatic test_same_edge();
        ox = 10'd500;
        tick();
        press_start();
        do_wraps(5);
        ox = 10'd2; dx = 10'd880; tick();
        n_total++;
        if (state !== 2'b01 || score !== 16'd5)
            $display("FAIL same_edge_setup: state=%b score=%0d, want 01 5", state, score);
        else n_pass++;
        ox = 10'd896; tick();
        n_total++;
        if (state !== 2'b10 || score !== 16'd5 || high !== 16'd5)
            $display("FAIL same_edge: state=%b score=%0d high=%0d, want 10 5 5", state, score, high);
        else n_pass++;
    endtask

    task automatic test_saturate();
        dx = 10'd100; dy = 10'd0; ox = 10'd500;
        repeat (10) tick();
        press_start();
        press_start();
        n_total++;
        if (state !== 2'b01) $display("FAIL sat_start: state=%b, want 01", state);
        else n_pass++;
        for (int i = 0; i < 65535 + 80; i++) begin
            ox = ox + 10'd1;
            tick();
        end
        n_total++;
        if (score !== 16'hFFFF || score !== 16'(m_score))
            $display("FAIL sat_reach: score=%h, want FFFF (model %h)", score, 16'(m_score));
        else n_pass++;
        do_wraps(3);
        n_total++;
        if (score !== 16'hFFFF) $display("FAIL sat_hold: score=%h, want FFFF", score);
        else n_pass++;
        dy = 10'd400; ox = 10'd110; tick();
        n_total++;
        if (state !== 2'b10 || high !== 16'hFFFF)
            $display("FAIL sat_high: state=%b high=%h, want 10 FFFF", state, high);
        else n_pass++;
    endtask

    task automatic test_rst_midrun();
        rst = 1'b1; tick(); rst = 1'b0;
        dx = 10'd100; dy = 10'd400; ox = 10'd500;
        press_start();
        do_wraps(9);
        ox = 10'd110; tick();
        ox = 10'd500;
        repeat (10) tick();
        press_start();
        press_start();
        do_wraps(7);
        n_total++;
        if (state !== 2'b01 || score !== 16'd7 || high !== 16'd9)
            $display("FAIL rst_setup: state=%b score=%0d high=%0d, want 01 7 9", state, score, high);
        else n_pass++;
        ox = 10'd110; rst = 1'b1; tick(); rst = 1'b0;
        n_total++;
        if ({state, score, high, coll} !== 35'd0)
            $display("FAIL rst_midrun: state=%b score=%0d high=%0d coll=%b, want all 0", state, score, high, coll);
        else n_pass++;
        ox = 10'd500; tick();
    endtask

    task automatic test_random();
        int x;
        int bad;
        bad = 0;
        x = 500;
        dx = 10'd100;
        for (int i = 0; i < 4000; i++) begin
            x = x - int'($urandom_range(1, 12));
            if (x < 20) x = 896;
            ox = 10'(x);
            if ($urandom_range(0, 49) == 0) dy = ($urandom_range(0, 1) == 0) ? 10'd400 : 10'd300;
            if ($urandom_range(0, 5) == 0) jump = ~jump;
            rst = ($urandom_range(0, 799) == 0);
            tick();
            n_total++;
            if (state !== 2'(m_state) || score !== 16'(m_score) ||
                high !== 16'(m_high) || coll !== m_coll) begin
                if (bad < 10)
                    $display("FAIL random_cyc%0d: got st=%b sc=%0d hi=%0d co=%b, want st=%0d sc=%0d hi=%0d co=%b",
                             i, state, score, high, coll, m_state, m_score, m_high, m_coll);
                bad++;
            end else n_pass++;
        end
        rst = 1'b0; jump = 1'b0;
    endtask

    initial begin
        test_reset();
        test_start();
        test_score();
        test_collision();
        test_hold();
        test_same_edge();
        test_saturate();
        test_rst_midrun();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
